// File: rtl/sram_write_stager.sv
// Staging FIFO between the SRAM write collector and the local SRAM write port.
// Completed-linear notifications are fenced until every earlier write has drained.
module sram_write_stager #(
  parameter int unsigned LBW         = 10,
  parameter int unsigned DBW         = 16,
  parameter int unsigned VSIZE       = 32,
  parameter int unsigned N_ICFG      = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_MARGIN = 2,
  localparam int unsigned CV_BW      = $clog2(VSIZE),
  localparam int unsigned HBW        = LBW - CV_BW,
  localparam int unsigned ICFG_BW    = $clog2(N_ICFG + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       w_dval,
  input  logic [ICFG_BW-1:0]         i_id,
  input  logic [HBW-1:0]             i_hiaddr,
  input  logic [VSIZE-1:0][DBW-1:0]  i_data,
  output logic                       sram_rdy,
  input  logic                       sram_ack,
  output logic [ICFG_BW-1:0]         o_sram_id,
  output logic [HBW-1:0]             o_sram_hiaddr,
  output logic [VSIZE-1:0][DBW-1:0]  o_sram_data,
  input  logic                       done_in_rdy,
  output logic                       done_in_ack,
  input  logic [LBW-1:0]             i_linear,
  input  logic [ICFG_BW-1:0]         i_linear_id,
  output logic                       done_out_rdy,
  input  logic                       done_out_ack,
  output logic [LBW-1:0]             o_linear,
  output logic [ICFG_BW-1:0]         o_linear_id,
  output logic                       o_hold,
  output logic                       o_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StHold} fence_state_e;

  logic [ICFG_BW-1:0]        r_id     [DEPTH];
  logic [HBW-1:0]            r_hiaddr [DEPTH];
  logic [VSIZE-1:0][DBW-1:0] r_data   [DEPTH];
  logic [PW-1:0]             r_wptr, r_rptr;
  logic [CW-1:0]             r_count, w_count_next;
  logic                      r_overflow, r_hold;
  logic                      w_push, w_pop, w_empty, w_full;
  fence_state_e              r_state, w_state_next;
  logic [LBW-1:0]            r_linear;
  logic [ICFG_BW-1:0]        r_linear_id;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && sram_ack;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push  = w_dval && (!w_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_id[i]     <= '0;
        r_hiaddr[i] <= '0;
        r_data[i]   <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      if (w_push) begin
        r_id[r_wptr]     <= i_id;
        r_hiaddr[r_wptr] <= i_hiaddr;
        r_data[r_wptr]   <= i_data;
        r_wptr           <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
      if (w_dval && !w_push) begin
        r_overflow <= 1'b1;
      end
      // Looks one write ahead to cover the collector's enable-to-dval latency.
      r_hold <= (w_count_next >= CW'(DEPTH - HOLD_MARGIN));
    end
  end

  assign sram_rdy      = !w_empty;
  assign o_sram_id     = r_id[r_rptr];
  assign o_sram_hiaddr = r_hiaddr[r_rptr];
  assign o_sram_data   = r_data[r_rptr];
  assign o_hold        = r_hold;
  assign o_overflow    = r_overflow;

  // A commit is taken only when no write of its linear is queued or arriving.
  always_comb begin
    w_state_next = r_state;
    done_in_ack  = 1'b0;
    done_out_rdy = 1'b0;
    unique case (r_state)
      StIdle: begin
        done_in_ack = done_in_rdy && w_empty && !w_dval && !i_rst;
        if (done_in_ack) begin
          w_state_next = StHold;
        end
      end
      StHold: begin
        done_out_rdy = 1'b1;
        if (done_out_ack) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_linear    <= '0;
      r_linear_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && done_in_ack) begin
        r_linear    <= i_linear;
        r_linear_id <= i_linear_id;
      end
    end
  end

  assign o_linear    = r_linear;
  assign o_linear_id = r_linear_id;

endmodule

// File: tb/tb_sram_write_stager.sv
// Bench for sram_write_stager: write scoreboard checked every cycle, a vector table
// for fill/stall/overflow, and directed sequences for fencing and reset.
module tb_sram_write_stager;
  localparam int unsigned LBW   = 10;
  localparam int unsigned DBW   = 16;
  localparam int unsigned VSIZE = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HBW   = 5;
  localparam int unsigned IBW   = 3;

  typedef logic [VSIZE-1:0][DBW-1:0] vdata_t;
  typedef struct {
    logic [IBW-1:0] id;
    logic [HBW-1:0] hiaddr;
    vdata_t         data;
  } sb_t;
  typedef struct {
    logic           dval;
    logic [HBW-1:0] hiaddr;
    logic           ack;
    logic           e_rdy;
    logic           e_hold;
    logic           e_ovf;
  } vec_t;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           w_dval;
  logic [IBW-1:0] i_id;
  logic [HBW-1:0] i_hiaddr;
  vdata_t         i_data;
  logic           sram_rdy, sram_ack;
  logic [IBW-1:0] o_sram_id;
  logic [HBW-1:0] o_sram_hiaddr;
  vdata_t         o_sram_data;
  logic           done_in_rdy, done_in_ack;
  logic [LBW-1:0] i_linear, o_linear;
  logic [IBW-1:0] i_linear_id, o_linear_id;
  logic           done_out_rdy, done_out_ack;
  logic           o_hold, o_overflow;

  int n_checks = 0;
  int n_errs   = 0;

  sram_write_stager #(
    .LBW(LBW), .DBW(DBW), .VSIZE(VSIZE), .N_ICFG(4), .DEPTH(DEPTH), .HOLD_MARGIN(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .w_dval(w_dval), .i_id(i_id), .i_hiaddr(i_hiaddr),
    .i_data(i_data), .sram_rdy(sram_rdy), .sram_ack(sram_ack), .o_sram_id(o_sram_id),
    .o_sram_hiaddr(o_sram_hiaddr), .o_sram_data(o_sram_data), .done_in_rdy(done_in_rdy),
    .done_in_ack(done_in_ack), .i_linear(i_linear), .i_linear_id(i_linear_id),
    .done_out_rdy(done_out_rdy), .done_out_ack(done_out_ack), .o_linear(o_linear),
    .o_linear_id(o_linear_id), .o_hold(o_hold), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vdata_t gen_data(input int s);
    vdata_t d;
    for (int i = 0; i < int'(VSIZE); i++) d[i] = 16'(s * 256 + i);
    return d;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference FIFO model, evaluated at the falling edge when inputs are stable.
  sb_t  sb[$];
  int   m_cnt  = 0;
  logic m_ovf  = 1'b0;
  logic m_hold = 1'b0;

  task automatic monitor();
    sb_t  e;
    logic p;
    logic q;
    if (i_rst) begin
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_hold = 1'b0;
      sb.delete();
      return;
    end
    chk("sb_rdy", sram_rdy, m_cnt != 0);
    chk("sb_hold", o_hold, m_hold);
    chk("sb_ovf", o_overflow, m_ovf);
    p = (m_cnt != 0) && sram_ack;
    q = 1'b0;
    if (p) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("sb_id", o_sram_id, e.id);
        chk("sb_hiaddr", o_sram_hiaddr, e.hiaddr);
        chk("sb_data", o_sram_data, e.data);
      end
    end
    if (w_dval) begin
      if (m_cnt < int'(DEPTH) || p) begin
        e.id = i_id;
        e.hiaddr = i_hiaddr;
        e.data = i_data;
        sb.push_back(e);
        q = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_cnt  = m_cnt + int'(q) - int'(p);
    m_hold = (m_cnt >= 2);
  endtask

  initial forever begin
    @(negedge i_clk);
    monitor();
  end

  task automatic single_write(input string tag);
    w_dval = 1'b1; i_id = 3'd1; i_hiaddr = 5'd5; i_data = gen_data(0); sram_ack = 1'b1;
    tick();
    w_dval = 1'b0;
    chk({tag, "_rdy1"}, sram_rdy, 1'b1);
    chk({tag, "_hiaddr"}, o_sram_hiaddr, 5'd5);
    chk({tag, "_id"}, o_sram_id, 3'd1);
    chk({tag, "_data31"}, o_sram_data[31], 16'd31);
    tick();
    chk({tag, "_rdy0"}, sram_rdy, 1'b0);
    sram_ack = 1'b0;
  endtask

  vec_t tbl[11];
  int   got;

  initial begin
    tbl[0]  = '{1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    i_rst = 1'b1; w_dval = 1'b0; i_id = '0; i_hiaddr = '0; i_data = '0; sram_ack = 1'b0;
    done_in_rdy = 1'b0; i_linear = '0; i_linear_id = '0; done_out_ack = 1'b0;
    tick();
    tick();
    chk("rst_rdy", sram_rdy, 1'b0);
    chk("rst_done_in_ack", done_in_ack, 1'b0);
    chk("rst_done_out_rdy", done_out_rdy, 1'b0);
    chk("rst_hold", o_hold, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_linear", {o_linear, o_linear_id}, '0);
    chk("rst_head", {o_sram_id, o_sram_hiaddr, o_sram_data}, '0);
    i_rst = 1'b0;
    tick();

    single_write("single");

    // Fill, push+pop at full, overflow, then drain in order.
    for (int k = 0; k < 11; k++) begin
      w_dval   = tbl[k].dval;
      i_hiaddr = tbl[k].hiaddr;
      i_id     = tbl[k].hiaddr[2:0];
      i_data   = gen_data(int'(tbl[k].hiaddr) + 1);
      sram_ack = tbl[k].ack;
      tick();
      chk($sformatf("tbl%0d_rdy", k), sram_rdy, tbl[k].e_rdy);
      chk($sformatf("tbl%0d_hold", k), o_hold, tbl[k].e_hold);
      chk($sformatf("tbl%0d_ovf", k), o_overflow, tbl[k].e_ovf);
    end
    w_dval = 1'b0; sram_ack = 1'b0;

    // Fence with two queued writes.
    for (int k = 0; k < 2; k++) begin
      w_dval = 1'b1; i_hiaddr = 5'(10 + k); i_id = 3'(k); i_data = gen_data(40 + k);
      tick();
    end
    w_dval = 1'b0; done_in_rdy = 1'b1; i_linear = 10'h040; i_linear_id = 3'd2;
    sram_ack = 1'b1;
    got = -1;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (done_in_ack) begin
        got = k;
        break;
      end
      tick();
    end
    chk("fence_ack_cycle", got, 2);
    tick();
    done_in_rdy = 1'b0; sram_ack = 1'b0; i_linear = '0; i_linear_id = '0;
    chk("fence_out_rdy", done_out_rdy, 1'b1);
    chk("fence_linear", o_linear, 10'h040);
    chk("fence_linear_id", o_linear_id, 3'd2);
    done_in_rdy = 1'b1;
    #2;
    chk("fence_hold_no_in_ack", done_in_ack, 1'b0);
    tick();
    tick();
    chk("fence_out_held", done_out_rdy, 1'b1);
    done_in_rdy = 1'b0; done_out_ack = 1'b1;
    tick();
    done_out_ack = 1'b0;
    chk("fence_out_released", done_out_rdy, 1'b0);

    // Commit request coincides with a write into an empty FIFO.
    done_in_rdy = 1'b1; i_linear = 10'h123; i_linear_id = 3'd3;
    w_dval = 1'b1; i_hiaddr = 5'd20; i_id = 3'd4; i_data = gen_data(77);
    #2;
    chk("dval_blocks_ack", done_in_ack, 1'b0);
    tick();
    w_dval = 1'b0;
    #2;
    chk("queued_blocks_ack", done_in_ack, 1'b0);
    tick();
    sram_ack = 1'b1;
    got = -1;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (done_in_ack) begin
        got = k;
        break;
      end
      tick();
    end
    chk("dval_fence_ack_cycle", got, 1);
    tick();
    done_in_rdy = 1'b0; sram_ack = 1'b0;
    chk("dval_fence_linear", o_linear, 10'h123);

    // Reset with three writes queued and a commit outstanding.
    for (int k = 0; k < 3; k++) begin
      w_dval = 1'b1; i_hiaddr = 5'(24 + k); i_id = 3'(k); i_data = gen_data(90 + k);
      tick();
    end
    w_dval = 1'b0;
    chk("pre_rst_rdy", sram_rdy, 1'b1);
    chk("pre_rst_out_rdy", done_out_rdy, 1'b1);
    chk("pre_rst_ovf", o_overflow, 1'b1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_rdy", sram_rdy, 1'b0);
    chk("mid_rst_out_rdy", done_out_rdy, 1'b0);
    chk("mid_rst_ovf", o_overflow, 1'b0);
    chk("mid_rst_linear", o_linear, '0);
    tick();
    i_rst = 1'b0;
    tick();
    single_write("post_rst");
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
